// File: rtl/data_mem_bank_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_bank_pkg
// Shared types for the data memory bank:
//   mem_in_s      core -> memory request (write_data, valid, wen,
//                 byte_not_word, yumi)
//   mem_out_s     memory -> core response (valid, read_data, yumi)
//   dmem_state_e  request FSM states of data_mem_bank
// Helper functions:
//   lane_mask  one-hot byte enable for a little-endian byte lane
//   lane_zext  selected byte lane of a word, zero-extended to 32 bits
// ----------------------------------------------------------------------------
package data_mem_bank_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic        valid;
        logic [31:0] read_data;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WAIT,
        D_RESP
    } dmem_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] lane_zext(input logic [31:0] word,
                                              input logic [1:0]  lane);
        return {24'b0, word[{lane, 3'b000} +: 8]};
    endfunction

endpackage

// File: rtl/data_mem_bank_dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Single-ported synchronous word RAM with a registered read, a 4-bit byte
// enable on the core port, and a separate full-word preload port used by the
// network loader. Contents are never reset.
// Ports:
//   clk        rising-edge clock
//   en         core port access (read always, write when wen)
//   wen        core port write enable
//   be         core port byte enables, bit n covers wdata[8n+7:8n]
//   addr       core port word address
//   wdata      core port write data
//   rdata      registered read data, updated only on en
//   init_wen   preload full-word write enable
//   init_addr  preload word address
//   init_data  preload data
// ----------------------------------------------------------------------------
module dmem_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    wen,
    input  logic [3:0]              be,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata,
    input  logic                    init_wen,
    input  logic [addr_width_p-1:0] init_addr,
    input  logic [31:0]             init_data
);

    localparam int depth_lp = 1 << addr_width_p;

    logic [31:0] mem [depth_lp];

    // The read samples the array before this edge's writes land, so an access
    // that also writes returns the old contents. The core write is scheduled
    // after the preload write, so when both hit the same word on one edge the
    // core bytes are the ones that stick. rdata only moves on an access, which
    // keeps the response data steady while the core stalls.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
        end
        if (init_wen) begin
            mem[init_addr] <= init_data;
        end
        if (en && wen) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/data_mem_bank.sv
// ----------------------------------------------------------------------------
// data_mem_bank
// Data memory slave behind the core's memory stage. Handles one request at a
// time with a two-phase valid/yumi handshake: the request is accepted (yumi)
// in IDLE, the response is presented latency_p cycles later and held until the
// core acknowledges it. Supports word and byte accesses and a preload port.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low
//   to_mem_i     request: write_data, valid, wen, byte_not_word, response yumi
//   addr_i       byte address; word index addr_i[2 +: addr_width_p]
//   from_mem_o   response: valid, read_data, request yumi
//   init_wen_i   preload full-word write
//   init_addr_i  preload word address
//   init_data_i  preload data
//   busy_o       high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module data_mem_bank
    import data_mem_bank_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  mem_in_s                 to_mem_i,
    input  logic [31:0]             addr_i,
    output mem_out_s                from_mem_o,
    input  logic                    init_wen_i,
    input  logic [addr_width_p-1:0] init_addr_i,
    input  logic [31:0]             init_data_i,
    output logic                    busy_o
);

    localparam logic [3:0] count_load_lp = 4'(latency_p - 1);

    dmem_state_e state;
    logic [3:0]  counter;
    logic        req_wen;
    logic        req_byte;
    logic [1:0]  req_lane;

    logic        accept;
    logic [3:0]  core_be;
    logic [31:0] core_wdata;
    logic [31:0] array_rdata;
    logic        unused_addr_bits;

    // Address bits above the word index are dropped on purpose so that
    // accesses wrap modulo the depth of the array.
    assign unused_addr_bits = ^addr_i[31:addr_width_p+2];

    // A request is taken only while idle; holding reset also holds off the
    // accept so nothing reaches the array while the bank is being cleared.
    assign accept = reset && (state == D_IDLE) && to_mem_i.valid;

    // Byte stores replicate the low byte onto every lane and let the byte
    // enable pick the one that lands; word stores enable all four lanes and
    // ignore the low address bits.
    always_comb begin
        core_be    = 4'hF;
        core_wdata = to_mem_i.write_data;
        if (to_mem_i.byte_not_word) begin
            core_be    = lane_mask(addr_i[1:0]);
            core_wdata = {4{to_mem_i.write_data[7:0]}};
        end
    end

    dmem_array #(
        .addr_width_p(addr_width_p)
    ) u_array (
        .clk       (clk),
        .en        (accept),
        .wen       (accept && to_mem_i.wen),
        .be        (core_be),
        .addr      (addr_i[2 +: addr_width_p]),
        .wdata     (core_wdata),
        .rdata     (array_rdata),
        .init_wen  (init_wen_i),
        .init_addr (init_addr_i),
        .init_data (init_data_i)
    );

    // Request FSM. The accept edge captures what the response formatting needs
    // later and loads the latency counter. WAIT moves to RESP on the edge
    // where the counter runs out, which makes the response appear exactly
    // latency_p cycles after the accept. RESP waits as long as the core
    // wants before it acknowledges with yumi.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= D_IDLE;
            counter  <= 4'd0;
            req_wen  <= 1'b0;
            req_byte <= 1'b0;
            req_lane <= 2'd0;
        end else begin
            case (state)
                D_IDLE: begin
                    if (accept) begin
                        req_wen  <= to_mem_i.wen;
                        req_byte <= to_mem_i.byte_not_word;
                        req_lane <= addr_i[1:0];
                        counter  <= count_load_lp;
                        state    <= (latency_p == 1) ? D_RESP : D_WAIT;
                    end
                end
                D_WAIT: begin
                    counter <= counter - 4'd1;
                    if (counter <= 4'd1) begin
                        counter <= 4'd0;
                        state   <= D_RESP;
                    end
                end
                D_RESP: begin
                    if (to_mem_i.yumi) begin
                        state <= D_IDLE;
                    end
                end
                default: begin
                    state <= D_IDLE;
                end
            endcase
        end
    end

    // Response formatting. Data is only driven while the response is valid;
    // stores answer with zero and byte loads return the captured lane
    // zero-extended.
    always_comb begin
        from_mem_o      = '0;
        from_mem_o.yumi = accept;
        if (state == D_RESP) begin
            from_mem_o.valid = 1'b1;
            if (!req_wen) begin
                from_mem_o.read_data = req_byte ? lane_zext(array_rdata, req_lane)
                                                : array_rdata;
            end
        end
    end

    assign busy_o = (state != D_IDLE);

endmodule

// File: tb/tb_data_mem_bank.sv
// ----------------------------------------------------------------------------
// tb_data_mem_bank
// Directed bench for data_mem_bank. One instance runs with latency 2 for the
// main access sequence, a second runs with latency 1 for the single-cycle
// response and back-to-back store throughput. Inputs change on the falling
// edge, outputs are sampled on the falling edge or 1 ns after an input change.
// ----------------------------------------------------------------------------
module tb_data_mem_bank;
    import data_mem_bank_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    mem_in_s     to_mem;
    logic [31:0] addr;
    mem_out_s    from_mem;
    logic        init_wen;
    logic [9:0]  init_addr;
    logic [31:0] init_data;
    logic        busy;

    mem_in_s     to_mem1;
    logic [31:0] addr1;
    mem_out_s    from_mem1;
    logic        init_wen1;
    logic [9:0]  init_addr1;
    logic [31:0] init_data1;
    logic        busy1;

    int          test_count = 0;
    int          fail_count = 0;
    int          cycles;
    logic        prev_valid;
    logic [11:0] accept_mask;

    data_mem_bank #(.addr_width_p(10), .latency_p(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .to_mem_i    (to_mem),
        .addr_i      (addr),
        .from_mem_o  (from_mem),
        .init_wen_i  (init_wen),
        .init_addr_i (init_addr),
        .init_data_i (init_data),
        .busy_o      (busy)
    );

    data_mem_bank #(.addr_width_p(10), .latency_p(1)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .to_mem_i    (to_mem1),
        .addr_i      (addr1),
        .from_mem_o  (from_mem1),
        .init_wen_i  (init_wen1),
        .init_addr_i (init_addr1),
        .init_data_i (init_data1),
        .busy_o      (busy1)
    );

    always #5 clk = ~clk;

    // Hard stop in case a wait somewhere never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wen, input logic bnw,
                                 input logic [31:0] wdata, input logic [31:0] a);
        to_mem.valid         = valid;
        to_mem.wen           = wen;
        to_mem.byte_not_word = bnw;
        to_mem.write_data    = wdata;
        addr                 = a;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        init_wen  = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_wen  = 1'b0;
    endtask

    // Full request on the latency-2 instance: accept, wait for the response,
    // check latency and data, acknowledge, confirm idle. An optional preload
    // write is driven on the same edge as the accept.
    task automatic runRequest(input logic wen, input logic bnw, input logic [31:0] wdata,
                              input logic [31:0] a, input logic [31:0] expd,
                              input logic ini, input logic [9:0] iaddr,
                              input logic [31:0] idata, input string tag);
        @(negedge clk);
        applyStimulus(1'b1, wen, bnw, wdata, a);
        to_mem.yumi = 1'b0;
        init_wen    = ini;
        init_addr   = iaddr;
        init_data   = idata;
        #1 checkOutput({tag, " accept"}, 32'(from_mem.yumi), 32'd1);
        @(negedge clk);
        to_mem.valid = 1'b0;
        init_wen     = 1'b0;
        cycles       = 1;
        while (!from_mem.valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'd2);
        checkOutput({tag, " data"}, from_mem.read_data, expd);
        to_mem.yumi = 1'b1;
        @(negedge clk);
        to_mem.yumi = 1'b0;
        #1 checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        to_mem    = '0;
        addr      = '0;
        init_wen  = 1'b0;
        init_addr = '0;
        init_data = '0;
        to_mem1   = '0;
        addr1     = '0;
        init_wen1 = 1'b0;
        init_addr1 = '0;
        init_data1 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset valid", 32'(from_mem.valid), 32'd0);
        checkOutput("reset yumi", 32'(from_mem.yumi), 32'd0);
        checkOutput("reset data", from_mem.read_data, 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // Preload and word load with latency 2
        preload(10'd5, 32'hDEADBEEF);
        runRequest(1'b0, 1'b0, 32'd0, 32'd20, 32'hDEADBEEF, 1'b0, 10'd0, 32'd0, "word load");

        // Byte store into lane 2, then word and byte loads
        runRequest(1'b1, 1'b1, 32'h000000A5, 32'd22, 32'd0, 1'b0, 10'd0, 32'd0, "byte store");
        runRequest(1'b0, 1'b0, 32'd0, 32'd20, 32'hDEA5BEEF, 1'b0, 10'd0, 32'd0, "merged word");
        runRequest(1'b0, 1'b1, 32'd0, 32'd23, 32'h000000DE, 1'b0, 10'd0, 32'd0, "byte load 3");
        runRequest(1'b0, 1'b1, 32'd0, 32'd22, 32'h000000A5, 1'b0, 10'd0, 32'd0, "byte load 2");

        // Core stalls the response for five cycles
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd20);
        #1 checkOutput("stall accept", 32'(from_mem.yumi), 32'd1);
        @(negedge clk);
        to_mem.valid = 1'b0;
        cycles = 1;
        while (!from_mem.valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("stall latency", 32'(cycles), 32'd2);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd20);
                #1 checkOutput("stall second yumi", 32'(from_mem.yumi), 32'd0);
            end
            checkOutput("stall valid", 32'(from_mem.valid), 32'd1);
            checkOutput("stall data", from_mem.read_data, 32'hDEA5BEEF);
            @(negedge clk);
        end
        to_mem.yumi = 1'b1;
        #1 checkOutput("release no yumi", 32'(from_mem.yumi), 32'd0);
        @(negedge clk);
        to_mem.yumi = 1'b0;
        #1 checkOutput("accept after release", 32'(from_mem.yumi), 32'd1);
        @(negedge clk);
        to_mem.valid = 1'b0;
        @(negedge clk);
        checkOutput("second resp data", from_mem.read_data, 32'hDEA5BEEF);
        to_mem.yumi = 1'b1;
        @(negedge clk);
        to_mem.yumi = 1'b0;

        // Reset while waiting for the response
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd20);
        @(negedge clk);
        to_mem.valid = 1'b0;
        #1 checkOutput("wait busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1 checkOutput("reset in wait busy", 32'(busy), 32'd0);
        checkOutput("reset in wait valid", 32'(from_mem.valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runRequest(1'b0, 1'b0, 32'd0, 32'd20, 32'hDEA5BEEF, 1'b0, 10'd0, 32'd0, "reissue");

        // Address aliasing and same-edge preload collisions
        runRequest(1'b0, 1'b0, 32'd0, 32'h00001014, 32'hDEA5BEEF, 1'b0, 10'd0, 32'd0, "alias");
        preload(10'd7, 32'h0BADF00D);
        runRequest(1'b0, 1'b0, 32'd0, 32'd28, 32'h0BADF00D, 1'b1, 10'd7, 32'h77777777, "old on init");
        runRequest(1'b0, 1'b0, 32'd0, 32'd28, 32'h77777777, 1'b0, 10'd0, 32'd0, "init landed");
        runRequest(1'b1, 1'b0, 32'h12345678, 32'd36, 32'd0, 1'b1, 10'd9, 32'h11111111, "collide store");
        runRequest(1'b0, 1'b0, 32'd0, 32'd36, 32'h12345678, 1'b0, 10'd0, 32'd0, "core wins");

        // Latency 1: back-to-back stores, core acknowledges one cycle after
        // it sees valid, request valid held high throughout
        prev_valid  = 1'b0;
        accept_mask = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            to_mem1.yumi          = prev_valid;
            to_mem1.valid         = 1'b1;
            to_mem1.wen           = 1'b1;
            to_mem1.byte_not_word = 1'b0;
            to_mem1.write_data    = 32'(c);
            addr1                 = 32'(c * 4);
            #1;
            accept_mask[c] = from_mem1.yumi;
            prev_valid     = from_mem1.valid;
        end
        checkOutput("b2b accept pattern", 32'(accept_mask), 32'h00000249);
        @(negedge clk);
        to_mem1 = '0;
        @(negedge clk);
        to_mem1.valid = 1'b1;
        addr1 = 32'd24;
        #1 checkOutput("lat1 accept", 32'(from_mem1.yumi), 32'd1);
        @(negedge clk);
        to_mem1.valid = 1'b0;
        checkOutput("lat1 valid", 32'(from_mem1.valid), 32'd1);
        checkOutput("lat1 data", from_mem1.read_data, 32'd6);
        to_mem1.yumi = 1'b1;
        @(negedge clk);
        to_mem1.yumi = 1'b0;
        #1 checkOutput("lat1 idle", 32'(busy1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
